picoctrl_prog_loader: RTL



---
 rtl/picoctrl_loader_pkg.sv | 27 ++
 rtl/picoctrl_prog_mem_array.sv | 35 +++
 rtl/picoctrl_prog_loader.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/picoctrl_loader_pkg.sv
// Shared constants for the PicoCTRL program loader: state encoding,
// frame limits and small decode helpers.
package picoctrl_loader_pkg;

  localparam int BYTE_W    = 8;
  localparam int MAX_WORDS = 32;
  localparam int STATE_W   = 3;

  // Loader FSM state encoding.
  localparam logic [STATE_W-1:0] ST_IDLE = 3'd0;
  localparam logic [STATE_W-1:0] ST_CNT  = 3'd1;
  localparam logic [STATE_W-1:0] ST_HI   = 3'd2;
  localparam logic [STATE_W-1:0] ST_LO   = 3'd3;
  localparam logic [STATE_W-1:0] ST_CSUM = 3'd4;
  localparam logic [STATE_W-1:0] ST_ERR  = 3'd5;

  // A count byte is legal when it names between 1 and MAX_WORDS words.
  function automatic logic count_ok(input logic [BYTE_W-1:0] n);
    return (n != '0) && (n <= BYTE_W'(MAX_WORDS));
  endfunction

  // States in which the loader takes a byte from the host link.
  function automatic logic is_load_state(input logic [STATE_W-1:0] s);
    return (s == ST_CNT) || (s == ST_HI) || (s == ST_LO) || (s == ST_CSUM);
  endfunction

endpackage

// File: rtl/picoctrl_prog_mem_array.sv
// DEPTH x DATA_W program store: one synchronous write port, one
// combinational read port, cleared to zero by the asynchronous reset.
module picoctrl_prog_mem_array #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 16,
  parameter int DEPTH  = 32
) (
  input  logic              clk,
  input  logic              res,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  // Write port; the whole store clears on reset.
  // NOTE: this store is a flop-based register file, not a RAM macro, so it
  // can take the async reset; a real SRAM could not be cleared this way.
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // The fetch port must see the addressed word in the same cycle.
  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/picoctrl_prog_loader.sv
// Loadable PicoCTRL program memory. A byte-stream loader writes a framed
// program (count, N big-endian words, XOR checksum) into the store and
// holds the controller in reset while a load is in progress or has failed.
module picoctrl_prog_loader
  import picoctrl_loader_pkg::*;
#(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 16,
  parameter int DEPTH  = 32
) (
  input  logic              clk,
  input  logic              res,
  input  logic [ADDR_W-1:0] rom_addr,
  output logic [DATA_W-1:0] rom_data,
  input  logic              ld_start,
  input  logic [BYTE_W-1:0] ld_byte,
  input  logic              ld_valid,
  output logic              ld_ready,
  output logic              ld_done,
  output logic              ld_err,
  output logic              cpu_res_n
);

  logic [STATE_W-1:0] state_q, state_d;
  logic [ADDR_W-1:0]  wr_addr_q, wr_addr_d;
  logic [ADDR_W-1:0]  last_addr_q, last_addr_d;
  logic [BYTE_W-1:0]  hi_q, hi_d;
  logic [BYTE_W-1:0]  csum_q, csum_d;
  logic               done_q, done_d;
  logic               err_q, err_d;
  logic               cpu_run_q, cpu_run_d;

  logic               accept;
  logic               mem_we;
  logic [DATA_W-1:0]  mem_wdata;

  // A start pulse outranks a byte offered in the same cycle.
  assign accept    = ld_valid & ld_ready & ~ld_start;
  assign mem_we    = accept && (state_q == ST_LO);
  assign mem_wdata = {hi_q, ld_byte};

  // Next-state, counter and checksum logic for the frame loader.
  // NOTE: every next-state signal is given its hold value before any branch,
  // so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d     = state_q;
    wr_addr_d   = wr_addr_q;
    last_addr_d = last_addr_q;
    hi_d        = hi_q;
    csum_d      = csum_q;
    done_d      = 1'b0;
    err_d       = err_q;

    if (ld_start) begin
      state_d   = ST_CNT;
      wr_addr_d = '0;
      csum_d    = '0;
      err_d     = 1'b0;
    end else if (accept) begin
      case (state_q)
        ST_CNT: begin
          if (count_ok(ld_byte)) begin
            last_addr_d = ADDR_W'(ld_byte - 8'd1);
            csum_d      = csum_q ^ ld_byte;
            state_d     = ST_HI;
          end else begin
            state_d = ST_ERR;
            err_d   = 1'b1;
          end
        end
        ST_HI: begin
          hi_d    = ld_byte;
          csum_d  = csum_q ^ ld_byte;
          state_d = ST_LO;
        end
        ST_LO: begin
          csum_d = csum_q ^ ld_byte;
          if (wr_addr_q == last_addr_q) begin
            state_d = ST_CSUM;
          end else begin
            wr_addr_d = wr_addr_q + ADDR_W'(1);
            state_d   = ST_HI;
          end
        end
        ST_CSUM: begin
          if (ld_byte == csum_q) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = ST_ERR;
            err_d   = 1'b1;
          end
        end
        default: begin
          state_d = state_q;
        end
      endcase
    end

    // The controller runs only while the loader rests in IDLE.
    cpu_run_d = (state_d == ST_IDLE);
  end

  // Loader state registers.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      state_q     <= ST_IDLE;
      wr_addr_q   <= '0;
      last_addr_q <= '0;
      hi_q        <= '0;
      csum_q      <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      cpu_run_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_addr_q   <= wr_addr_d;
      last_addr_q <= last_addr_d;
      hi_q        <= hi_d;
      csum_q      <= csum_d;
      done_q      <= done_d;
      err_q       <= err_d;
      cpu_run_q   <= cpu_run_d;
    end
  end

  assign ld_ready  = is_load_state(state_q);
  assign ld_done   = done_q;
  assign ld_err    = err_q;
  assign cpu_res_n = cpu_run_q;

  picoctrl_prog_mem_array #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_mem (
    .clk     (clk),
    .res     (res),
    .we_i    (mem_we),
    .waddr_i (wr_addr_q),
    .wdata_i (mem_wdata),
    .raddr_i (rom_addr),
    .rdata_o (rom_data)
  );

endmodule
